adc_sample_stats: RTL and testbench

Multi-channel ADC sample capture and statistics block placed between the `ltc2308` reader and the `adctest` video generator / audio path. It turns the reader's toggle-based `dout_sync` into per-sample valid pulses and latches every channel. It also produces per-channel block averages over a run-time-selectable power-of-two length and min/max peak values over a fixed sample window. All of this runs in one clock domain, the ADC clock.

---
 rtl/adc_stats_pkg.sv | 17 +
 rtl/adc_stats_chan.sv | 93 +++++++++
 rtl/adc_sample_stats.sv | 113 +++++++++++
 tb/tb_adc_sample_stats.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_stats_pkg.sv
// Shared types, width helper and tracker seed values for the ADC statistics block.
package adc_stats_pkg;

  localparam int unsigned SAMPLE_BITS = 12;

  typedef logic [SAMPLE_BITS-1:0] sample_t;

  localparam sample_t MIN_SEED = '1;
  localparam sample_t MAX_SEED = '0;

  // Accumulator width that holds 2^avg_log2_max full-scale samples without overflow.
  function automatic int unsigned acc_w(input int unsigned adc_bits,
                                        input int unsigned avg_log2_max);
    return adc_bits + avg_log2_max;
  endfunction

endpackage

// File: rtl/adc_stats_chan.sv
// Per-channel statistics: block accumulator, min/max trackers and sticky clip flag.
module adc_stats_chan
  import adc_stats_pkg::*;
#(
  parameter int unsigned ADC_BITS     = 12,
  parameter int unsigned AVG_LOG2_MAX = 6,
  parameter int unsigned NL_W         = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stat_en,
  input  logic                clear,
  input  logic                last_avg,
  input  logic                last_peak,
  input  logic [NL_W-1:0]     n_sh,
  input  logic [ADC_BITS-1:0] s,
  output logic [ADC_BITS-1:0] avg,
  output logic [ADC_BITS-1:0] peak_min,
  output logic [ADC_BITS-1:0] peak_max,
  output logic                clip
);

  localparam int unsigned ACC_W = acc_w(ADC_BITS, AVG_LOG2_MAX);

  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [ADC_BITS-1:0] min_q, min_d, max_q, max_d, nmin, nmax;
  logic [ADC_BITS-1:0] avg_q, avg_d, pmin_q, pmin_d, pmax_q, pmax_d;
  logic                clip_q, clip_d;

  // Next-state for accumulator, trackers, result registers and clip flag.
  always_comb begin
    acc_d  = acc_q;
    min_d  = min_q;
    max_d  = max_q;
    avg_d  = avg_q;
    pmin_d = pmin_q;
    pmax_d = pmax_q;
    clip_d = clip_q;
    sum    = acc_q + ACC_W'(s);
    nmin   = (s < min_q) ? s : min_q;
    nmax   = (s > max_q) ? s : max_q;
    if (clear) begin
      acc_d  = '0;
      min_d  = '1;
      max_d  = '0;
      clip_d = 1'b0;
    end else if (stat_en) begin
      if (last_avg) begin
        avg_d = ADC_BITS'(sum >> n_sh);
        acc_d = '0;
      end else begin
        acc_d = sum;
      end
      if (last_peak) begin
        pmin_d = nmin;
        pmax_d = nmax;
        min_d  = '1;
        max_d  = '0;
      end else begin
        min_d = nmin;
        max_d = nmax;
      end
      if ((s == '0) || (s == '1)) clip_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      min_q  <= '1;
      max_q  <= '0;
      avg_q  <= '0;
      pmin_q <= '0;
      pmax_q <= '0;
      clip_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      min_q  <= min_d;
      max_q  <= max_d;
      avg_q  <= avg_d;
      pmin_q <= pmin_d;
      pmax_q <= pmax_d;
      clip_q <= clip_d;
    end
  end

  assign avg      = avg_q;
  assign peak_min = pmin_q;
  assign peak_max = pmax_q;
  assign clip     = clip_q;

endmodule

// File: rtl/adc_sample_stats.sv
// ADC sample capture from toggle sync, with per-channel block averages and window peaks.
module adc_sample_stats
  import adc_stats_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned ADC_BITS     = 12,
  parameter int unsigned AVG_LOG2_MAX = 6,
  parameter int unsigned PEAK_WIN     = 96000
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CH*ADC_BITS-1:0]           din,
  input  logic                                 din_sync,
  input  logic [$clog2(AVG_LOG2_MAX+1)-1:0]    avg_log2,
  input  logic                                 clear,
  output logic [NUM_CH*ADC_BITS-1:0]           sample,
  output logic                                 sample_valid,
  output logic [NUM_CH*ADC_BITS-1:0]           avg,
  output logic                                 avg_valid,
  output logic [NUM_CH*ADC_BITS-1:0]           peak_min,
  output logic [NUM_CH*ADC_BITS-1:0]           peak_max,
  output logic                                 peak_valid,
  output logic [NUM_CH-1:0]                    clip
);

  localparam int unsigned NL_W  = $clog2(AVG_LOG2_MAX+1);
  localparam int unsigned CNT_W = AVG_LOG2_MAX + 1;
  localparam int unsigned PCW   = $clog2(PEAK_WIN);

  logic                       sync_q, sync_d, edge_det;
  logic [NUM_CH*ADC_BITS-1:0] sample_q, sample_d;
  logic                       sv_q, sv_d, av_q, av_d, pv_q, pv_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PCW-1:0]             pcnt_q, pcnt_d;
  logic [NL_W-1:0]            n_lat_q, n_lat_d, n_sat, n_eff;
  logic                       stat_en, last_avg, last_peak;

  // Edge detect, capture stage and shared window counters.
  always_comb begin
    edge_det  = din_sync ^ sync_q;
    sync_d    = din_sync;
    sample_d  = edge_det ? din : sample_q;
    sv_d      = edge_det;
    n_sat     = (avg_log2 > NL_W'(AVG_LOG2_MAX)) ? NL_W'(AVG_LOG2_MAX) : avg_log2;
    // A new window takes the live setting on its first sample; later samples use the latch.
    n_eff     = (cnt_q == '0) ? n_sat : n_lat_q;
    n_lat_d   = (cnt_q == '0) ? n_sat : n_lat_q;
    stat_en   = sv_q & ~clear;
    last_avg  = (cnt_q == ((CNT_W'(1) << n_eff) - CNT_W'(1)));
    last_peak = (pcnt_q == PCW'(PEAK_WIN - 1));
    av_d      = stat_en & last_avg;
    pv_d      = stat_en & last_peak;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    if (clear) begin
      cnt_d  = '0;
      pcnt_d = '0;
    end else if (stat_en) begin
      cnt_d  = last_avg  ? '0 : cnt_q + CNT_W'(1);
      pcnt_d = last_peak ? '0 : pcnt_q + PCW'(1);
    end
  end

  // Shared registers; sync follows din_sync during reset to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q   <= din_sync;
      sample_q <= '0;
      sv_q     <= 1'b0;
      av_q     <= 1'b0;
      pv_q     <= 1'b0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      n_lat_q  <= '0;
    end else begin
      sync_q   <= sync_d;
      sample_q <= sample_d;
      sv_q     <= sv_d;
      av_q     <= av_d;
      pv_q     <= pv_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      n_lat_q  <= n_lat_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    adc_stats_chan #(
      .ADC_BITS    (ADC_BITS),
      .AVG_LOG2_MAX(AVG_LOG2_MAX),
      .NL_W        (NL_W)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .stat_en  (stat_en),
      .clear    (clear),
      .last_avg (last_avg),
      .last_peak(last_peak),
      .n_sh     (n_eff),
      .s        (sample_q[k*ADC_BITS +: ADC_BITS]),
      .avg      (avg[k*ADC_BITS +: ADC_BITS]),
      .peak_min (peak_min[k*ADC_BITS +: ADC_BITS]),
      .peak_max (peak_max[k*ADC_BITS +: ADC_BITS]),
      .clip     (clip[k])
    );
  end

  assign sample       = sample_q;
  assign sample_valid = sv_q;
  assign avg_valid    = av_q;
  assign peak_valid   = pv_q;

endmodule

// File: tb/tb_adc_sample_stats.sv
// Directed self-checking bench for adc_sample_stats (PEAK_WIN overridden to 4).
module tb_adc_sample_stats;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] din;
  logic        din_sync;
  logic [2:0]  avg_log2;
  logic        clear;
  logic [23:0] sample, avg, peak_min, peak_max;
  logic        sample_valid, avg_valid, peak_valid;
  logic [1:0]  clip;

  int total = 0;
  int bad   = 0;

  adc_sample_stats #(
    .NUM_CH      (2),
    .ADC_BITS    (12),
    .AVG_LOG2_MAX(6),
    .PEAK_WIN    (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .din_sync    (din_sync),
    .avg_log2    (avg_log2),
    .clear       (clear),
    .sample      (sample),
    .sample_valid(sample_valid),
    .avg         (avg),
    .avg_valid   (avg_valid),
    .peak_min    (peak_min),
    .peak_max    (peak_max),
    .peak_valid  (peak_valid),
    .clip        (clip)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic [11:0] c1, input logic [11:0] c0);
    din      = {c1, c0};
    din_sync = ~din_sync;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  // Feed one sample and advance to the cycle where stage-2 results are visible.
  task automatic feed(input logic [11:0] c1, input logic [11:0] c0);
    toggle(c1, c0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    din_sync = 1'b1;
    din      = 24'h0;
    avg_log2 = 3'd0;
    clear    = 1'b0;
    repeat (3) tick();
    total++;
    if ({sample, avg, peak_min, peak_max} !== 96'h0) begin
      bad++; $display("FAIL reset_data got %h %h %h %h want 0", sample, avg, peak_min, peak_max);
    end
    total++;
    if ({sample_valid, avg_valid, peak_valid, clip} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got %b%b%b %b want 0", sample_valid, avg_valid, peak_valid, clip);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sample_valid !== 1'b0) begin
        bad++; $display("FAIL no_spurious_edge cyc %0d got %b want 0", i, sample_valid);
      end
    end
  endtask

  task automatic test_single();
    toggle(12'h800, 12'h123);
    tick();
    total++;
    if (sample_valid !== 1'b1 || sample !== 24'h800123) begin
      bad++; $display("FAIL single_capture got v=%b %h want v=1 800123", sample_valid, sample);
    end
    tick();
    total++;
    if (sample_valid !== 1'b0 || avg_valid !== 1'b1 || avg !== 24'h800123) begin
      bad++; $display("FAIL single_avg0 got sv=%b av=%b %h want sv=0 av=1 800123", sample_valid, avg_valid, avg);
    end
  endtask

  task automatic test_avg();
    int nav;
    do_clear();
    avg_log2 = 3'd2;
    nav = 0;
    feed(12'd10, 12'd100); nav += avg_valid;
    feed(12'd20, 12'd101); nav += avg_valid;
    feed(12'd30, 12'd102); nav += avg_valid;
    total++;
    if (nav !== 0) begin
      bad++; $display("FAIL avg_early got %0d pulses want 0", nav);
    end
    feed(12'd41, 12'd104);
    total++;
    if (avg_valid !== 1'b1 || avg !== {12'd25, 12'd101}) begin
      bad++; $display("FAIL avg_4 got v=%b %h want v=1 %h", avg_valid, avg, {12'd25, 12'd101});
    end
    total++;
    if (peak_valid !== 1'b1 || peak_min !== {12'd10, 12'd100} || peak_max !== {12'd41, 12'd104}) begin
      bad++; $display("FAIL avg_peaks got v=%b %h %h want v=1 %h %h", peak_valid, peak_min, peak_max,
                      {12'd10, 12'd100}, {12'd41, 12'd104});
    end
  endtask

  task automatic test_midwin();
    int nav;
    do_clear();
    avg_log2 = 3'd2;
    nav = 0;
    feed(12'd4, 12'd8); nav += avg_valid;
    feed(12'd4, 12'd8); nav += avg_valid;
    avg_log2 = 3'd0;
    feed(12'd4, 12'd8); nav += avg_valid;
    total++;
    if (nav !== 0) begin
      bad++; $display("FAIL midwin_early got %0d pulses want 0", nav);
    end
    feed(12'd4, 12'd12);
    total++;
    if (avg_valid !== 1'b1 || avg !== {12'd4, 12'd9}) begin
      bad++; $display("FAIL midwin_close got v=%b %h want v=1 %h", avg_valid, avg, {12'd4, 12'd9});
    end
    feed(12'd55, 12'd77);
    total++;
    if (avg_valid !== 1'b1 || avg !== {12'd55, 12'd77}) begin
      bad++; $display("FAIL midwin_n0_a got v=%b %h want v=1 %h", avg_valid, avg, {12'd55, 12'd77});
    end
    feed(12'd66, 12'd88);
    total++;
    if (avg_valid !== 1'b1 || avg !== {12'd66, 12'd88}) begin
      bad++; $display("FAIL midwin_n0_b got v=%b %h want v=1 %h", avg_valid, avg, {12'd66, 12'd88});
    end
  endtask

  task automatic test_peak();
    int npv;
    do_clear();
    npv = 0;
    feed(12'd5,   12'd50); npv += peak_valid;
    feed(12'd900, 12'd60); npv += peak_valid;
    feed(12'd3,   12'd70); npv += peak_valid;
    feed(12'd7,   12'd80); npv += peak_valid;
    tick(); npv += peak_valid;
    total++;
    if (npv !== 1) begin
      bad++; $display("FAIL peak_count got %0d pulses want 1", npv);
    end
    total++;
    if (peak_min !== {12'd3, 12'd50} || peak_max !== {12'd900, 12'd80}) begin
      bad++; $display("FAIL peak_vals got %h %h want %h %h", peak_min, peak_max,
                      {12'd3, 12'd50}, {12'd900, 12'd80});
    end
  endtask

  task automatic test_clear_prio();
    do_clear();
    avg_log2 = 3'd2;
    toggle(12'd40, 12'hFFF);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (clip !== 2'b00 || avg_valid !== 1'b0) begin
      bad++; $display("FAIL clrprio_clip got clip=%b av=%b want 00 0", clip, avg_valid);
    end
    feed(12'd40, 12'd20);
    feed(12'd40, 12'd20);
    feed(12'd40, 12'd20);
    total++;
    if (avg_valid !== 1'b0) begin
      bad++; $display("FAIL clrprio_third got av=%b want 0", avg_valid);
    end
    feed(12'd40, 12'd20);
    total++;
    if (avg_valid !== 1'b1 || avg !== {12'd40, 12'd20} || peak_max !== {12'd40, 12'd20}) begin
      bad++; $display("FAIL clrprio_fourth got av=%b %h pmax=%h want 1 %h", avg_valid, avg, peak_max,
                      {12'd40, 12'd20});
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    avg_log2 = 3'd0;
    toggle(12'h100, 12'h000);
    tick();
    total++;
    if (sample_valid !== 1'b1 || sample !== 24'h100000) begin
      bad++; $display("FAIL b2b_first got v=%b %h want 1 100000", sample_valid, sample);
    end
    toggle(12'h200, 12'h300);
    tick();
    total++;
    if (sample_valid !== 1'b1 || sample !== 24'h200300 || avg_valid !== 1'b1 || avg !== 24'h100000) begin
      bad++; $display("FAIL b2b_second got sv=%b %h av=%b %h want 1 200300 1 100000",
                      sample_valid, sample, avg_valid, avg);
    end
    tick();
    total++;
    if (sample_valid !== 1'b0 || avg_valid !== 1'b1 || avg !== 24'h200300 || clip !== 2'b01) begin
      bad++; $display("FAIL b2b_third got sv=%b av=%b %h clip=%b want 0 1 200300 01",
                      sample_valid, avg_valid, avg, clip);
    end
    feed(12'h123, 12'h456);
    feed(12'h321, 12'h654);
    total++;
    if (clip !== 2'b01) begin
      bad++; $display("FAIL clip_sticky got %b want 01", clip);
    end
    do_clear();
    total++;
    if (clip !== 2'b00 || avg !== {12'h321, 12'h654}) begin
      bad++; $display("FAIL clip_clear got clip=%b avg=%h want 00 %h", clip, avg, {12'h321, 12'h654});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_avg();
    test_midwin();
    test_peak();
    test_clear_prio();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
